// File: rtl/seq_pulse_tx.sv
// Serial P1/P2 symbol transmitter: sends a latched pattern MSB-first,
// one pulse per symbol, with GAP idle cycles after each symbol.
module seq_pulse_tx #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int GAP     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               P1,
  output logic               P2,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GLAST =
    GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [LEN_W-1:0] LMAX = LEN_W'(MAX_LEN);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] sr_q, sr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]      gcnt_q, gcnt_d;
  logic               p1_q, p1_d;
  logic               p2_q, p2_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [LEN_W-1:0]   len_eff;

  assign len_eff = (len > LMAX) ? LMAX : len;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_eff != '0) begin
            // left-align so the first symbol sits in the MSB
            state_d = ST_SEND;
            sr_d    = pattern << (LMAX - len_eff);
            cnt_d   = len_eff;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SEND: begin
        sr_d  = sr_q << 1;
        cnt_d = cnt_q - LEN_W'(1);
        if (abort) begin
          state_d = ST_IDLE;
        end else if (GAP > 0) begin
          state_d = ST_GAP;
          gcnt_d  = GLAST;
        end else if (cnt_q > LEN_W'(1)) begin
          state_d = ST_SEND;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (gcnt_q != '0) begin
          gcnt_d = gcnt_q - GW'(1);
        end else if (cnt_q != '0) begin
          state_d = ST_SEND;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // outputs are registered from the state being entered
  always_comb begin
    p1_d   = (state_d == ST_SEND) && sr_d[MAX_LEN-1];
    p2_d   = (state_d == ST_SEND) && !sr_d[MAX_LEN-1];
    busy_d = (state_d == ST_SEND) || (state_d == ST_GAP);
    done_d = (state_d == ST_DONE);
  end

  assign P1   = p1_q;
  assign P2   = p2_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_pulse_tx.sv
// Bench for seq_pulse_tx: GAP=1 and GAP=0 instances on shared inputs,
// timeline model plus hand-computed cycle expectations.
module tb_seq_pulse_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] len;

  logic p1_0, p2_0, busy_0, done_0;
  logic p1_1, p2_1, busy_1, done_1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_pulse_tx #(.MAX_LEN(8), .LEN_W(4), .GAP(0)) u0 (
    .clk(clk), .reset(reset), .start(start),
    .abort(abort), .pattern(pattern), .len(len),
    .P1(p1_0), .P2(p2_0), .busy(busy_0), .done(done_0)
  );

  seq_pulse_tx #(.MAX_LEN(8), .LEN_W(4), .GAP(1)) u1 (
    .clk(clk), .reset(reset), .start(start),
    .abort(abort), .pattern(pattern), .len(len),
    .P1(p1_1), .P2(p2_1), .busy(busy_1), .done(done_1)
  );

  // Model: a transfer is a timeline of per-cycle {P1,P2,busy,done}
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic [3:0] cur0 = '0;
  logic [3:0] cur1 = '0;

  task automatic build(input int g, input logic [7:0] pat,
                       input logic [3:0] ln,
                       output logic [3:0] tl[$]);
    int n;
    tl.delete();
    n = (ln > 4'd8) ? 8 : int'(ln);
    for (int i = n - 1; i >= 0; i--) begin
      tl.push_back(pat[i] ? 4'b1010 : 4'b0110);
      for (int k = 0; k < g; k++) tl.push_back(4'b0010);
    end
    tl.push_back(4'b0001);
  endtask

  always @(posedge clk or negedge reset) begin : model0
    logic [3:0] nx;
    logic [3:0] tl[$];
    if (!reset) begin
      q0.delete();
      cur0 <= '0;
    end else begin
      if (cur0[1] && abort) begin
        q0.delete();
        nx = '0;
      end else if (q0.size() > 0) begin
        nx = q0.pop_front();
      end else if (!cur0[0] && start) begin
        build(0, pattern, len, tl);
        q0 = tl;
        nx = q0.pop_front();
      end else begin
        nx = '0;
      end
      cur0 <= nx;
    end
  end

  always @(posedge clk or negedge reset) begin : model1
    logic [3:0] nx;
    logic [3:0] tl[$];
    if (!reset) begin
      q1.delete();
      cur1 <= '0;
    end else begin
      if (cur1[1] && abort) begin
        q1.delete();
        nx = '0;
      end else if (q1.size() > 0) begin
        nx = q1.pop_front();
      end else if (!cur1[0] && start) begin
        build(1, pattern, len, tl);
        q1 = tl;
        nx = q1.pop_front();
      end else begin
        nx = '0;
      end
      cur1 <= nx;
    end
  end

  task automatic cmp(input string nm, input logic [3:0] got,
                     input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b required %b",
               nm, $time, got, exp);
    end
    n_chk++;
    if (got[3] && got[2]) begin
      n_fail++;
      $display("FAIL %s_excl at %0t: P1 and P2 both high",
               nm, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("model_g0", {p1_0, p2_0, busy_0, done_0}, cur0);
    cmp("model_g1", {p1_1, p2_1, busy_1, done_1}, cur1);
  end

  task automatic chk(input string nm, input logic got,
                     input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b required %b",
               nm, $time, got, exp);
    end
  endtask

  function automatic logic [3:0] outs(input int inst);
    if (inst == 0) return {p1_0, p2_0, busy_0, done_0};
    return {p1_1, p2_1, busy_1, done_1};
  endfunction

  // start already raised; checks cycles 1..9 against bit c-1
  task automatic run_lit(input string nm, input int inst,
                         input logic [8:0] ep1,
                         input logic [8:0] ep2,
                         input logic [8:0] eb,
                         input logic [8:0] ed);
    logic [3:0] o;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      o = outs(inst);
      chk({nm, "_P1"}, o[3], ep1[c-1]);
      chk({nm, "_P2"}, o[2], ep2[c-1]);
      chk({nm, "_busy"}, o[1], eb[c-1]);
      chk({nm, "_done"}, o[0], ed[c-1]);
      if (c < 9) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int np0, np1;
    reset   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = '0;
    len     = '0;
    idle(2);
    chk("rst_P1", p1_1, 1'b0);
    chk("rst_busy", busy_1, 1'b0);
    chk("rst_done", done_0, 1'b0);
    reset = 1'b1;
    idle(2);

    // GAP=1 four-symbol transfer
    pattern = 8'b0000_1101;
    len     = 4'd4;
    start   = 1'b1;
    run_lit("t1", 1, 9'b001000101, 9'b000010000,
            9'b011111111, 9'b100000000);
    idle(4);

    // GAP=0 eight-symbol back-to-back
    pattern = 8'b1010_0101;
    len     = 4'd8;
    start   = 1'b1;
    run_lit("t2", 0, 9'b010100101, 9'b001011010,
            9'b011111111, 9'b100000000);
    idle(15);

    // len=0: done only
    len   = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("len0_done1", done_1, 1'b1);
    chk("len0_busy1", busy_1, 1'b0);
    chk("len0_done0", done_0, 1'b1);
    chk("len0_P1", p1_1 | p2_1, 1'b0);
    idle(3);

    // len=12 clamps to 8 symbols
    pattern = 8'hA5;
    len     = 4'd12;
    start   = 1'b1;
    np0 = 0;
    np1 = 0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      np0 += int'(p1_0) + int'(p2_0);
      np1 += int'(p1_1) + int'(p2_1);
      @(negedge clk);
    end
    n_chk++;
    if (np0 != 8 || np1 != 8) begin
      n_fail++;
      $display("FAIL len12_count: got %0d/%0d required 8/8",
               np0, np1);
    end
    idle(3);

    // start re-pulsed and pattern changed mid-transfer
    pattern = 8'b0000_1101;
    len     = 4'd4;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_c1_P1", p1_1, 1'b1);
    idle(2);
    start   = 1'b1;
    pattern = 8'hFF;
    len     = 4'd8;
    chk("mid_c3_P1", p1_1, 1'b1);
    idle(2);
    chk("mid_c5_P2", p2_1, 1'b1);
    idle(2);
    chk("mid_c7_P1", p1_1, 1'b1);
    idle(2);
    chk("mid_c9_done", done_1, 1'b1);
    idle(1);
    chk("mid_c10_busy", busy_1, 1'b0);
    idle(1);
    chk("mid_c11_busy", busy_1, 1'b1);
    chk("mid_c11_P1", p1_1, 1'b1);
    start = 1'b0;
    idle(25);

    // abort in the third symbol's gap cycle
    pattern = 8'b0000_1101;
    len     = 4'd4;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(5);
    chk("abort_c6_busy", busy_1, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_c7_busy", busy_1, 1'b0);
    chk("abort_c7_P1", p1_1, 1'b0);
    chk("abort_c7_P2", p2_1, 1'b0);
    for (int c = 7; c <= 12; c++) begin
      chk("abort_no_done", done_1, 1'b0);
      @(negedge clk);
    end

    // abort and start together in IDLE: start wins
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", busy_1, 1'b1);
    idle(12);

    // asynchronous reset mid-transfer
    pattern = 8'b0000_1101;
    len     = 4'd4;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(2);
    #2 reset = 1'b0;
    #1;
    chk("arst_P1", p1_1, 1'b0);
    chk("arst_busy", busy_1, 1'b0);
    chk("arst_busy0", busy_0, 1'b0);
    chk("arst_done", done_1, 1'b0);
    @(negedge clk);
    reset   = 1'b1;
    pattern = 8'b0000_0011;
    len     = 4'd2;
    start   = 1'b1;
    run_lit("post_rst", 1, 9'b000000101, 9'b000000000,
            9'b000001111, 9'b000010000);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_pulse_tx.md
Name: seq_pulse_tx

Overview:
- Serial sequence transmitter for the two-line symbol encoding used by the team's sequence detectors.
- P1 pulse = symbol '1'; P2 pulse = symbol '0'.
- Loads a pattern word on a start request and emits it MSB-first as one-cycle P1/P2 pulses, with a fixed number of idle cycles between symbols.
- Reports busy while transmitting and done on completion.
- Drives detector inputs in the lab top level and in benches.

Parameters:
- MAX_LEN, 8: pattern register width; maximum number of symbols per transfer.
- LEN_W, 4: width of the len port; must hold the value MAX_LEN.
- GAP, 1: idle cycles (P1=P2=0) after every symbol, including the last; 0 gives back-to-back symbols.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; low clears all state immediately.
- start  input  1  transfer request, sampled only in IDLE.
- abort  input  1  synchronous cancel of an active transfer.
- pattern  input  MAX_LEN  symbols to send; bit len-1 is sent first, bit 0 last.
- len  input  LEN_W  number of symbols to send.
- P1  output  1  registered one-cycle pulse, symbol '1'.
- P2  output  1  registered one-cycle pulse, symbol '0'.
- busy  output  1  high while in SEND or GAP.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; P1=0, P2=0, busy=0, done=0; shift register, symbol counter and gap counter cleared. Outputs stay at these values until the first rising edge after reset returns high.
- All outputs are registered. P1 and P2 are never both high.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - Edge with start=1 and len!=0: latch pattern and len, go to SEND. The first symbol appears on P1/P2 for the cycle that follows this edge; busy=1 from that cycle.
  - Edge with start=1 and len=0: go directly to DONE; no symbols are sent.
  - len>MAX_LEN: treated as MAX_LEN.
- SEND (exactly one cycle):
  - Drives P1=1 if the current bit is 1, otherwise P2=1.
  - Decrements the remaining count.
  - Next state is GAP if GAP>0. If GAP=0: SEND again when symbols remain, else DONE.
- GAP (exactly GAP cycles): P1=P2=0, busy=1. When the gap ends: SEND if symbols remain, else DONE.
- DONE (one cycle): done=1, busy=0, P1=P2=0; then IDLE.
- start is ignored outside IDLE. A new start is accepted on the first edge in IDLE, so consecutive transfers are separated by at least the DONE cycle.
- Latency: first symbol is 1 cycle after the start edge. A transfer occupies len×(GAP+1) busy cycles, then one done cycle.
- pattern and len are sampled only at acceptance; changing them mid-transfer has no effect.
- abort=1 in SEND or GAP: next state is IDLE; P1/P2/busy low on the next cycle; no done pulse.
- abort in IDLE or DONE: no effect.
- abort and start on the same edge in IDLE: start wins, because abort acts only in SEND/GAP.
- Reset mid-transfer: immediate return to IDLE outputs; no done pulse; transfer lost.

Test Plan:
- GAP=1, pattern=8'b0000_1101, len=4, start pulsed at edge 0 -> P1 in cycles 1 and 3, P2 in cycle 5, P1 in cycle 7; both low in cycles 2, 4, 6, 8; busy high in cycles 1–8; done high in cycle 9 only.
- GAP=0, pattern=8'b1010_0101, len=8 -> symbols 1,0,1,0,0,1,0,1 on P1/P2 in cycles 1–8 back-to-back; done in cycle 9; P1&P2 never both 1.
- len=0 with start -> no P1/P2 activity; done in cycle 1; busy stays 0. Separately, len=12 with MAX_LEN=8 -> exactly 8 symbols sent.
- start re-pulsed and pattern changed mid-transfer -> current transfer output unchanged; a second transfer starts only when start is held at the first IDLE edge after done.
- abort asserted during the 3rd symbol's GAP cycle (GAP=1, len=4) -> P1/P2/busy low from the next cycle; no done pulse.
- reset driven low asynchronously between edges mid-transfer -> P1/P2/busy/done low immediately. After release and a start with pattern=8'b0000_0011, len=2 -> P1, idle, P1, idle, then done.
